// File: rtl/univ_shift_reg.sv
// Sequenced universal shift register: one start runs `count` single-bit shifts, busy/done handshake.
// Optional rotate-right on mode 11 when USR_ROTATE_EN is defined; otherwise mode 11 is logical right.
module univ_shift_reg #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     din,
  input  logic             ld,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             shift_in,
  output logic [N-1:0]     dout,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] rem;
  logic [N-1:0]     sh_nxt;
  logic             sh_bit;

  // One-position shift of the current contents under the latched mode.
  always_comb begin
    sh_nxt = {shift_in, dout[N-1:1]};
    sh_bit = dout[0];
    case (mode_q)
      2'b00: begin
        sh_nxt = {dout[N-2:0], shift_in};
        sh_bit = dout[N-1];
      end
      2'b10: sh_nxt = {dout[N-1], dout[N-1:1]};
`ifdef USR_ROTATE_EN
      2'b11: sh_nxt = {dout[0], dout[N-1:1]};
`endif
      default: sh_nxt = {shift_in, dout[N-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      dout      <= '0;
      shift_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rem       <= '0;
      mode_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            dout <= din;
          end else if (start) begin
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              mode_q <= mode;
              rem    <= count;
              state  <= SHIFT;
              busy   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          dout      <= sh_nxt;
          shift_out <= sh_bit;
          rem       <= rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_univ_shift_reg;
  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [N-1:0]     din = '0;
  logic             ld = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [CNT_W-1:0] count = '0;
  logic             shift_in = 1'b0;
  logic [N-1:0]     dout;
  logic             shift_out;
  logic             busy;
  logic             done;

  univ_shift_reg #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .din(din), .ld(ld), .start(start), .mode(mode),
    .count(count), .shift_in(shift_in), .dout(dout), .shift_out(shift_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         so;
    logic         b;
    logic         dn;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [N-1:0] m_dout = '0;
  logic         m_so = 1'b0;

  task automatic cmp(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  // Reference: one shift expressed as plain arithmetic on the register value.
  task automatic mdl_shift(input logic [1:0] md, input logic si);
    logic [N-1:0] d;
    d = m_dout;
    case (md)
      2'b00: begin m_so = d[N-1]; m_dout = (d << 1) | N'(si); end
      2'b10: begin m_so = d[0];   m_dout = N'($signed(d) >>> 1); end
`ifdef USR_ROTATE_EN
      2'b11: begin m_so = d[0];   m_dout = (d >> 1) | (d << (N-1)); end
`endif
      default: begin m_so = d[0]; m_dout = (d >> 1) | (N'(si) << (N-1)); end
    endcase
  endtask

  task automatic push(input logic b, input logic dn);
    exp_t e;
    e.d = m_dout; e.so = m_so; e.b = b; e.dn = dn;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock in which the stimulus advanced the DUT.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("dout", dout, e.d);
      cmp("shift_out", N'(shift_out), N'(e.so));
      cmp("busy", N'(busy), N'(e.b));
      cmp("done", N'(done), N'(e.dn));
    end
  end

  task automatic do_clr();
    clr = 1'b1; ld = 1'b0; start = 1'b0;
    @(posedge clk);
    m_dout = '0; m_so = 1'b0;
    push(1'b0, 1'b0);
    #1 clr = 1'b0;
  endtask

  task automatic do_idle();
    ld = 1'b0; start = 1'b0; din = N'($urandom); shift_in = 1'($urandom);
    @(posedge clk);
    push(1'b0, 1'b0);
    #1;
  endtask

  task automatic do_ld(input logic [N-1:0] d, input logic with_start);
    ld = 1'b1; start = with_start; din = d;
    mode = 2'($urandom); count = CNT_W'($urandom_range(1, 15));
    @(posedge clk);
    m_dout = d;
    push(1'b0, 1'b0);
    #1 ld = 1'b0; start = 1'b0;
  endtask

  // junk: 0 quiet, 1 ld=1/din=FF/start=1 throughout, 2 random control noise.
  task automatic do_start(input logic [1:0] md, input int k, input int clr_after, input int junk,
                          input int si_mode);
    bit aborted = 0;
    ld = 1'b0; start = 1'b1; mode = md; count = CNT_W'(k);
    @(posedge clk);
    push(k != 0, k == 0);
    #1 start = 1'b0;
    for (int i = 1; i <= k && !aborted; i++) begin
      shift_in = (si_mode == 2) ? 1'($urandom) : 1'(si_mode);
      mode = 2'($urandom); count = CNT_W'($urandom);
      if (junk == 1) begin ld = 1'b1; start = 1'b1; din = 8'hFF; end
      else if (junk == 2) begin ld = 1'($urandom); start = 1'($urandom); din = N'($urandom); end
      if (i - 1 == clr_after) begin
        do_clr();
        aborted = 1;
      end else begin
        @(posedge clk);
        mdl_shift(md, shift_in);
        push(i < k, i == k);
        #1;
      end
    end
    do_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_clr();
    do_idle();
    // Directed cases
    do_ld(8'hA5, 1'b0);
    do_start(2'b00, 3, -1, 0, 1);
    do_ld(8'h90, 1'b0);
    do_start(2'b10, 2, -1, 0, 2);
    do_ld(8'h3C, 1'b0);
    do_start(2'($urandom), 0, -1, 0, 2);
    do_ld(8'h5A, 1'b0);
    do_start(2'b01, 4, -1, 1, 2);
    do_ld(8'h11, 1'b1);
    do_idle();
    do_ld(8'hF0, 1'b0);
    do_start(2'b01, 5, 2, 0, 0);
    do_start(2'b00, 1, -1, 0, 1);
    do_ld(8'h81, 1'b0);
    do_start(2'b11, 1, -1, 0, 0);
    do_ld(8'hC3, 1'b0);
    do_start(2'b11, 15, -1, 2, 2);
    // Randomised traffic
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        0, 1:    do_ld(N'($urandom), 1'($urandom));
        2:       do_idle();
        3:       do_clr();
        4:       do_start(2'($urandom), $urandom_range(0, 15), $urandom_range(0, 14), 2, 2);
        default: do_start(2'($urandom), $urandom_range(0, 15), -1, $urandom_range(0, 2), 2);
      endcase
    end
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
